// File: rtl/linked_list_fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain_pkg
//   Shared types and helpers for the linked-list FIFO drain engine.
//   - drain_state_t : scheduler states (WAIT_INIT, SCAN)
//   - BUF_ENTRIES   : depth of the landing/output buffer
//   - log2_ceil     : index width for n entries (minimum 1 bit)
//   - buf_ptr_inc   : wrap-at-2 increment for the 3-entry buffer pointers
// -----------------------------------------------------------------------------
package linked_list_fifo_drain_pkg;

    typedef enum logic {
        WAIT_INIT = 1'b0,
        SCAN      = 1'b1
    } drain_state_t;

    localparam int BUF_ENTRIES = 3;

    // Bits needed to index values 0..n-1; never returns less than 1.
    function automatic int log2_ceil(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return w;
    endfunction

    function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/linked_list_fifo_drain_out_buf.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain_out_buf
//   3-entry circular buffer that absorbs words landing from the linked-list
//   FIFO and presents them on a valid/ready stream.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     in_valid        write strobe (a popped word is landing this cycle)
//     in_data  [W]    word to append at the tail
//     out_valid       buffer non-empty
//     out_ready       downstream accept
//     out_data [W]    head word
//     count    [2]    occupancy (0..3), used by the producer's credit check
// -----------------------------------------------------------------------------
module linked_list_fifo_drain_out_buf
    import linked_list_fifo_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [BUF_ENTRIES];
    logic [1:0]   head;
    logic [1:0]   tail;
    logic [1:0]   cnt;
    logic         deq;

    assign out_valid = (cnt != 2'd0);
    assign deq       = out_valid & out_ready;
    assign out_data  = mem[head];
    assign count     = cnt;

    // NOTE: storage is deliberately not reset; cnt alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (in_valid) mem[tail] <= in_data;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= 2'd0;
            tail <= 2'd0;
            cnt  <= 2'd0;
        end else begin
            if (in_valid) tail <= buf_ptr_inc(tail);
            if (deq)      head <= buf_ptr_inc(head);
            case ({in_valid, deq})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // The producer's credit check guarantees a landing never meets a full buffer.
    assert property (@(posedge clk) disable iff (rst) !(in_valid && cnt == 2'd3));

endmodule

// File: rtl/linked_list_fifo_drain.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain
//   Read-side engine for the shared linked-list multi-FIFO. Waits out the
//   free-list build after reset, then scans the logical FIFOs round-robin,
//   popping up to BURST words from each before moving on. Popped words land
//   one cycle later in a 3-entry buffer and leave on a valid/ready stream
//   tagged with their source FIFO.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     ll_pop              pop strobe to the linked-list FIFO
//     ll_pop_fifo [LF]    FIFO currently selected (the round-robin pointer)
//     ll_empty            empty flag of the selected FIFO (combinational)
//     ll_q [WIDTH]        pop data, valid the cycle after ll_pop
//     fifo_en [FIFOS]     per-FIFO service enable
//     out_valid/out_ready output handshake
//     out_data [WIDTH]    head word
//     out_fifo [LF]       source FIFO of the head word
//     busy                a pop is in flight or the buffer holds data
// -----------------------------------------------------------------------------
module linked_list_fifo_drain
    import linked_list_fifo_drain_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int FIFOS       = 8,
    parameter int LOG2_FIFOS  = log2_ceil(FIFOS),
    parameter int BURST       = 4,
    parameter int INIT_CYCLES = DEPTH + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ll_pop,
    output logic [LOG2_FIFOS-1:0] ll_pop_fifo,
    input  logic                  ll_empty,
    input  logic [WIDTH-1:0]      ll_q,
    input  logic [FIFOS-1:0]      fifo_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_FIFOS-1:0] out_fifo,
    output logic                  busy
);

    localparam int INIT_W  = log2_ceil(INIT_CYCLES);
    localparam int BURST_W = log2_ceil(BURST);
    localparam int TAG_W   = WIDTH + LOG2_FIFOS;

    drain_state_t          state;
    logic [INIT_W-1:0]     init_cnt;
    logic [LOG2_FIFOS-1:0] ptr;
    logic [LOG2_FIFOS-1:0] ptr_next;
    logic [BURST_W-1:0]    burst_cnt;
    logic                  inflight;
    logic [LOG2_FIFOS-1:0] tag;

    logic [1:0]            buf_count;
    logic [TAG_W-1:0]      buf_data;
    logic                  credit_ok;
    logic                  fifo_enabled;
    logic                  pop;

    // Words already committed (buffered + landing) must leave room for one more.
    assign credit_ok    = ({1'b0, buf_count} + {2'b00, inflight}) < 3'd3;
    assign fifo_enabled = fifo_en[ptr];
    // ll_empty depends only on ll_pop_fifo (= ptr, a register), so this path has no loop.
    assign pop          = (state == SCAN) && credit_ok && fifo_enabled && !ll_empty;

    assign ll_pop      = pop;
    assign ll_pop_fifo = ptr;
    assign ptr_next    = (ptr == LOG2_FIFOS'(FIFOS - 1)) ? '0 : ptr + LOG2_FIFOS'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_INIT;
            init_cnt  <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            inflight  <= 1'b0;
            tag       <= '0;
        end else begin
            inflight <= pop;
            if (pop) tag <= ptr;

            case (state)
                WAIT_INIT: begin
                    init_cnt <= init_cnt + INIT_W'(1);
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state <= SCAN;
                end
                SCAN: begin
                    if (pop) begin
                        if (burst_cnt == BURST_W'(BURST - 1)) begin
                            ptr       <= ptr_next;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end else if (!fifo_enabled || ll_empty) begin
                        ptr       <= ptr_next;
                        burst_cnt <= '0;
                    end
                    // Otherwise only credit blocked the pop: stay on this FIFO.
                end
                default: state <= WAIT_INIT;
            endcase
        end
    end

    linked_list_fifo_drain_out_buf #(
        .W (TAG_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight),
        .in_data   ({tag, ll_q}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_data),
        .count     (buf_count)
    );

    assign out_data = buf_data[WIDTH-1:0];
    assign out_fifo = buf_data[TAG_W-1:WIDTH];
    assign busy     = inflight | (buf_count != 2'd0);

endmodule
